// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock period meter and the divider benches:
// FSM encoding, default sizing and the duty-balance helper.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } meas_state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Operands arrive zero-extended to 32 bits, so the difference never wraps.
  function automatic logic within_one(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return (diff <= 32'd1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain for an asynchronous input plus a one-clock delayed copy
// used to detect rising and falling edges of the synchronized level.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);

  // Fewer than two flops would not give metastability a full cycle to settle.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_reg;
  logic         s_d_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      s_d_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[N-2:0], sig_in};
      s_d_reg  <= sync_reg[N-1];
    end
  end

  assign s    = sync_reg[N-1];
  assign rise = s & ~s_d_reg;
  assign fall = ~s & s_d_reg;

endmodule

// File: rtl/clk_period_meter.sv
// Measures high time, low time and period of a slow clock-like input in
// system-clock cycles, with a duty-balance flag and a sticky timeout.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W:0]   period,
  output logic             duty_ok,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  meas_state_t      state_reg, state_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic [CNT_W-1:0] h_reg;
  logic [CNT_W:0]   period_next;
  logic             s, rise, fall;
  logic             at_max;
  logic             load_meas, store_high, saturate;

  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .sig_in(sig_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  assign at_max      = (counter_reg == CNT_MAX);
  assign period_next = {1'b0, h_reg} + {1'b0, counter_reg};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:      state_next = WAIT_RISE;
        WAIT_RISE: if (rise) state_next = MEAS_HIGH;
        MEAS_HIGH: begin
          if (fall)        state_next = MEAS_LOW;
          else if (at_max) state_next = WAIT_RISE;
        end
        MEAS_LOW: begin
          if (rise)        state_next = MEAS_HIGH;
          else if (at_max) state_next = WAIT_RISE;
        end
        default:   state_next = IDLE;
      endcase
    end
  end

  // The edge that closes a phase is itself the first cycle of the next phase.
  always_comb begin
    counter_next = '0;
    load_meas    = 1'b0;
    store_high   = 1'b0;
    saturate     = 1'b0;
    if (enable) begin
      case (state_reg)
        WAIT_RISE: if (rise) counter_next = CNT_ONE;
        MEAS_HIGH: begin
          if (fall) begin
            store_high   = 1'b1;
            counter_next = CNT_ONE;
          end else if (at_max) begin
            saturate = 1'b1;
          end else if (s) begin
            counter_next = counter_reg + CNT_ONE;
          end else begin
            counter_next = counter_reg;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            load_meas    = 1'b1;
            counter_next = CNT_ONE;
          end else if (at_max) begin
            saturate = 1'b1;
          end else if (!s) begin
            counter_next = counter_reg + CNT_ONE;
          end else begin
            counter_next = counter_reg;
          end
        end
        default: counter_next = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter_reg <= '0;
      h_reg       <= '0;
      high_time   <= '0;
      low_time    <= '0;
      period      <= '0;
      duty_ok     <= 1'b0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      counter_reg <= counter_next;
      meas_valid  <= load_meas;
      if (store_high) begin
        h_reg <= counter_reg;
      end
      if (load_meas) begin
        high_time <= h_reg;
        low_time  <= counter_reg;
        period    <= period_next;
        duty_ok   <= within_one(32'(h_reg), 32'(counter_reg));
        timeout   <= 1'b0;
      end else if (saturate) begin
        timeout <= 1'b1;
      end else if (!enable || state_reg == IDLE) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench: a narrow (CNT_W=4) and a default-width meter share one
// stimulus; expected results come from the driven high/low run lengths.
module tb_clk_period_meter;

  localparam int SYNC    = 2;
  localparam int NW      = 4;
  localparam int WW      = 16;
  localparam int SAT_MAX = (1 << NW) - 1;

  logic clock = 1'b0;
  logic reset, enable, sig_in;

  logic [NW-1:0] ht4, lt4;
  logic [NW:0]   p4;
  logic          d4, v4, to4;
  logic [WW-1:0] htw, ltw;
  logic [WW:0]   pw;
  logic          dw, vw, tow;

  always #5 clock = ~clock;

  clk_period_meter #(.CNT_W(NW), .SYNC_STAGES(SYNC)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .high_time(ht4), .low_time(lt4), .period(p4), .duty_ok(d4),
    .meas_valid(v4), .timeout(to4)
  );

  clk_period_meter #(.CNT_W(WW), .SYNC_STAGES(SYNC)) dutw (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .high_time(htw), .low_time(ltw), .period(pw), .duty_ok(dw),
    .meas_valid(vw), .timeout(tow)
  );

  typedef struct {
    int h;
    int l;
    int p;
    bit d;
    int cyc;
  } exp_t;

  typedef struct {
    int h;
    int l;
    int n;
    int exp_h;
    int exp_l;
    int exp_p;
    bit exp_d;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pulses = 0;
  bit   check_wide = 1'b1;
  bit   prev_valid = 1'b0;
  int   prev_h, prev_l;
  int   last_h, last_l, last_p, last_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_pulse(input string tag, input logic v, input int ht, input int lt,
                           input int p, input logic d, input logic to, input exp_t e);
    chk({tag, "_valid"}, v, 1);
    chk({tag, "_high"}, ht, e.h);
    chk({tag, "_low"}, lt, e.l);
    chk({tag, "_period"}, p, e.p);
    chk({tag, "_duty"}, d, e.d);
    chk({tag, "_timeout"}, to, 0);
    chk({tag, "_latency_cyc"}, cyc, e.cyc);
  endtask

  // One clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (v4 || (check_wide && vw)) begin
      chk("pulse_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_pulse("n4", v4, int'(ht4), int'(lt4), int'(p4), d4, to4, e);
        if (check_wide) chk_pulse("wide", vw, int'(htw), int'(ltw), int'(pw), dw, tow, e);
        $display("pulse cyc=%0d high=%0d low=%0d period=%0d duty=%0d", cyc, ht4, lt4, p4, d4);
      end
      pulses++;
      last_h = int'(ht4);
      last_l = int'(lt4);
      last_p = int'(p4);
      last_d = int'(d4);
    end
  endtask

  // Reference: a rise closes the previous full period if one was armed.
  task automatic model_rise(input int h, input int l);
    exp_t e;
    if (prev_valid && prev_h <= SAT_MAX && prev_l <= SAT_MAX) begin
      e.h   = prev_h;
      e.l   = prev_l;
      e.p   = prev_h + prev_l;
      e.d   = ((prev_h > prev_l) ? prev_h - prev_l : prev_l - prev_h) <= 1;
      e.cyc = cyc + SYNC + 1;
      exp_q.push_back(e);
    end
    prev_h = h;
    prev_l = l;
    prev_valid = 1'b1;
  endtask

  task automatic drive_period(input int h, input int l);
    model_rise(h, l);
    sig_in = 1'b1;
    repeat (h) tick();
    sig_in = 1'b0;
    repeat (l) tick();
  endtask

  task automatic start_run();
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (2) tick();
    chk("idle_timeout_clear", to4, 0);
    chk("idle_no_valid", v4, 0);
    prev_valid = 1'b0;
    pulses = 0;
    enable = 1'b1;
    repeat (3) tick();
  endtask

  task automatic end_run(input string tag);
    sig_in = 1'b0;
    repeat (5) tick();
    chk({tag, "_missing_pulses"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_high"}, ht4, 0);
    chk({tag, "_low"}, lt4, 0);
    chk({tag, "_period"}, p4, 0);
    chk({tag, "_duty"}, d4, 0);
    chk({tag, "_valid"}, v4, 0);
    chk({tag, "_timeout"}, to4, 0);
    chk({tag, "_wide_period"}, pw, 0);
    chk({tag, "_wide_duty"}, dw, 0);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{4, 3, 5, 4, 3, 7, 1'b1};
    vt[1] = '{10, 2, 4, 10, 2, 12, 1'b0};
    vt[2] = '{1, 1, 6, 1, 1, 2, 1'b1};
    vt[3] = '{5, 5, 3, 5, 5, 10, 1'b1};
    vt[4] = '{15, 2, 3, 15, 2, 17, 1'b0};
    vt[5] = '{2, 15, 3, 2, 15, 17, 1'b0};
    vt[6] = '{6, 5, 3, 6, 5, 11, 1'b1};
    vt[7] = '{3, 5, 3, 3, 5, 8, 1'b0};

    reset = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_run();
      for (int k = 0; k < vt[i].n; k++) drive_period(vt[i].h, vt[i].l);
      end_run($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_pulses", i), pulses, vt[i].n - 1);
      chk($sformatf("vec%0d_high", i), last_h, vt[i].exp_h);
      chk($sformatf("vec%0d_low", i), last_l, vt[i].exp_l);
      chk($sformatf("vec%0d_period", i), last_p, vt[i].exp_p);
      chk($sformatf("vec%0d_duty", i), last_d, vt[i].exp_d);
    end

    // Random waveforms within the narrow counter's range.
    start_run();
    repeat (40) begin
      int h, l;
      h = int'($urandom_range(1, 14));
      l = int'($urandom_range(1, 14));
      drive_period(h, l);
    end
    end_run("random");

    // Enable dropped for 3 clocks in the low phase of a 5/5 waveform.
    start_run();
    repeat (3) drive_period(5, 5);
    model_rise(5, 5);
    sig_in = 1'b1;
    repeat (5) tick();
    sig_in = 1'b0;
    repeat (2) tick();
    enable = 1'b0;
    repeat (3) begin
      tick();
      chk("abort_hold_high", ht4, 5);
      chk("abort_hold_low", lt4, 5);
      chk("abort_hold_period", p4, 10);
    end
    prev_valid = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    pulses = 0;
    repeat (3) drive_period(5, 5);
    end_run("enable_drop");
    chk("enable_drop_pulses", pulses, 2);
    chk("enable_drop_high", last_h, 5);
    chk("enable_drop_period", last_p, 10);

    // Asynchronous reset in the middle of a low phase.
    start_run();
    repeat (3) drive_period(4, 3);
    model_rise(4, 3);
    sig_in = 1'b1;
    repeat (4) tick();
    sig_in = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    tick();
    reset = 1'b0;
    prev_valid = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    pulses = 0;
    repeat (3) drive_period(4, 3);
    end_run("after_reset");
    chk("after_reset_pulses", pulses, 2);

    // Saturation of the narrow meter: 16 high cycles exceed its 15-cycle limit.
    check_wide = 1'b0;
    start_run();
    chk("pre_sat_timeout", to4, 0);
    drive_period(16, 3);
    chk("sat_timeout_set", to4, 1);
    drive_period(3, 3);
    chk("sat_timeout_sticky", to4, 1);
    drive_period(3, 3);
    repeat (SYNC + 1) tick();
    chk("sat_timeout_cleared", to4, 0);
    chk("sat_recover_high", last_h, 3);
    chk("sat_recover_low", last_l, 3);
    end_run("saturation");
    chk("sat_pulses", pulses, 1);
    check_wide = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
